// File: rtl/aes_byte_host_if.sv
// Host byte-link front end for AES_top: assembles key/plaintext from a byte stream,
// runs the core with a bounded wait for its result, then streams the 16 result bytes back.
module aes_byte_host_if #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         core_en,
  output logic [127:0] core_data,
  output logic [127:0] core_key,
  input  logic [127:0] core_data_out,
  input  logic         core_data_out_valid,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_KEY  = 3'd1,
    LOAD_DATA = 3'd2,
    RUN       = 3'd3,
    SEND      = 3'd4
  } state_t;

  localparam logic [7:0]       CMD_KEY  = 8'h4B;
  localparam logic [7:0]       CMD_DATA = 8'h44;
  localparam logic [CNT_W-1:0] RUN_ONE  = 1;
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [3:0]       byte_cnt_reg, byte_cnt_next;
  logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
  logic [127:0]     key_reg, key_next;
  logic [127:0]     data_reg, data_next;
  logic [127:0]     result_reg, result_next;
  logic             timeout_err_reg, timeout_err_next;
  logic             rx_ready_reg, rx_ready_next;
  logic             rx_fire, tx_fire;
  logic [7:0]       result_bytes [16];

  // Result byte 0 is the most significant byte, sent first.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_result_bytes
      assign result_bytes[gi] = result_reg[127-8*gi -: 8];
    end
  endgenerate

  assign rx_fire = rx_valid && rx_ready_reg;
  assign tx_fire = tx_valid && tx_ready;

  always_comb begin
    state_next       = state_reg;
    byte_cnt_next    = byte_cnt_reg;
    run_cnt_next     = run_cnt_reg;
    key_next         = key_reg;
    data_next        = data_reg;
    result_next      = result_reg;
    timeout_err_next = timeout_err_reg;
    unique case (state_reg)
      IDLE: begin
        if (rx_fire) begin
          byte_cnt_next = 4'd0;
          if (rx_byte == CMD_KEY) begin
            state_next = LOAD_KEY;
          end else if (rx_byte == CMD_DATA) begin
            state_next       = LOAD_DATA;
            timeout_err_next = 1'b0;
          end
        end
      end
      LOAD_KEY: begin
        if (rx_fire) begin
          key_next      = {key_reg[119:0], rx_byte};
          byte_cnt_next = byte_cnt_reg + 4'd1;
          if (byte_cnt_reg == 4'd15) state_next = IDLE;
        end
      end
      LOAD_DATA: begin
        if (rx_fire) begin
          data_next     = {data_reg[119:0], rx_byte};
          byte_cnt_next = byte_cnt_reg + 4'd1;
          if (byte_cnt_reg == 4'd15) begin
            state_next   = RUN;
            run_cnt_next = '0;
          end
        end
      end
      RUN: begin
        run_cnt_next = run_cnt_reg + RUN_ONE;
        // A valid left over from a previous run is ignored in the first RUN cycle;
        // a valid in the final cycle still beats the timeout.
        if (run_cnt_reg != '0 && core_data_out_valid) begin
          result_next   = core_data_out;
          byte_cnt_next = 4'd0;
          state_next    = SEND;
        end else if (run_cnt_reg == RUN_LAST) begin
          timeout_err_next = 1'b1;
          state_next       = IDLE;
        end
      end
      SEND: begin
        if (tx_fire) begin
          byte_cnt_next = byte_cnt_reg + 4'd1;
          if (byte_cnt_reg == 4'd15) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    rx_ready_next = (state_next == IDLE) || (state_next == LOAD_KEY) ||
                    (state_next == LOAD_DATA);
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_reg       <= IDLE;
      byte_cnt_reg    <= 4'd0;
      run_cnt_reg     <= '0;
      key_reg         <= '0;
      data_reg        <= '0;
      result_reg      <= '0;
      timeout_err_reg <= 1'b0;
      rx_ready_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      byte_cnt_reg    <= byte_cnt_next;
      run_cnt_reg     <= run_cnt_next;
      key_reg         <= key_next;
      data_reg        <= data_next;
      result_reg      <= result_next;
      timeout_err_reg <= timeout_err_next;
      rx_ready_reg    <= rx_ready_next;
    end
  end

  // Outputs decode straight from registered state so the async reset clears them at once.
  assign rx_ready    = rx_ready_reg;
  assign tx_valid    = (state_reg == SEND);
  assign tx_byte     = tx_valid ? result_bytes[byte_cnt_reg] : 8'h00;
  assign core_en     = (state_reg == RUN);
  assign core_key    = key_reg;
  assign core_data   = data_reg;
  assign busy        = (state_reg != IDLE);
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_aes_byte_host_if.sv
// Randomised bench for aes_byte_host_if: host-level operations drive a per-cycle
// expectation of every output, plus literal checks from the reference vector.
module tb_aes_byte_host_if;

  localparam int TO = 64;

  logic         AES_clk = 1'b0;
  logic         AES_rst_n = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         core_en;
  logic [127:0] core_data, core_key;
  logic [127:0] core_data_out = '0;
  logic         core_data_out_valid = 1'b0;
  logic         busy, timeout_err;

  aes_byte_host_if #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .AES_clk(AES_clk), .AES_rst_n(AES_rst_n),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .core_en(core_en), .core_data(core_data), .core_key(core_key),
    .core_data_out(core_data_out), .core_data_out_valid(core_data_out_valid),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 AES_clk = ~AES_clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;
  logic exp_rx_ready, exp_busy, exp_en, exp_txv, exp_terr;
  logic [127:0] exp_key, exp_data, exp_res;
  int tx_idx;
  int en_cycles;
  logic [7:0] tx_log [$];

  localparam logic [127:0] KEY_VEC = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
  localparam logic [127:0] DAT_VEC = 128'h000000dd000000000000000000000000;
  localparam logic [127:0] RES_VEC = 128'h00112233445566778899aabbccddeeff;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Per-cycle comparison of every output against the expectation.
  always @(negedge AES_clk) begin
    if (chk_on) begin
      chk("rx_ready", rx_ready, exp_rx_ready);
      chk("busy", busy, exp_busy);
      chk("core_en", core_en, exp_en);
      chk("tx_valid", tx_valid, exp_txv);
      chk("timeout_err", timeout_err, exp_terr);
      chk("core_key", core_key, exp_key);
      chk("core_data", core_data, exp_data);
      if (exp_txv) chk("tx_byte", tx_byte, exp_res[127-8*tx_idx -: 8]);
    end
  end

  always @(posedge AES_clk) begin
    if (AES_rst_n && tx_valid && tx_ready) tx_log.push_back(tx_byte);
    if (core_en) en_cycles++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    #1 AES_rst_n = 1'b0;
    rx_valid = 1'b0; tx_ready = 1'b0; core_data_out_valid = 1'b0;
    #1;
    chk("rst core_en", core_en, 1'b0);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst tx_byte", tx_byte, 8'h00);
    chk("rst rx_ready", rx_ready, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst timeout_err", timeout_err, 1'b0);
    chk("rst core_key", core_key, 128'h0);
    chk("rst core_data", core_data, 128'h0);
    exp_key = '0; exp_data = '0; exp_terr = 0; exp_en = 0; exp_txv = 0;
    exp_busy = 0; exp_rx_ready = 0; tx_idx = 0;
    tick(); tick();
    #2 AES_rst_n = 1'b1;
    tick();
    exp_rx_ready = 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    if ($urandom_range(3) == 0) begin
      rx_valid = 1'b0; rx_byte = 8'($urandom);
      tick();
    end
    rx_byte = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    logic [127:0] old;
    old = exp_key;
    send_byte(8'h4B);
    exp_busy = 1;
    for (int i = 0; i < 16; i++) begin
      send_byte(k[127-8*i -: 8]);
      exp_key = (old << (8*(i+1))) | (k >> (8*(15-i)));
    end
    exp_busy = 0;
  endtask

  // One 0x44 operation. k = RUN cycle in which the core raises valid (>TO: never).
  // tx_mode: 0 ready always, 1 pattern 1,0,0,1, 2 random. rst_at_*: 0 = no reset.
  task automatic run_op(input logic [127:0] d, input logic [127:0] res, input int k,
                        input bit stale, input int tx_mode, input int rst_at_byte,
                        input int rst_at_run);
    logic [127:0] old;
    int cap;
    int guard;
    old = exp_data;
    tx_log.delete();
    en_cycles = 0;
    send_byte(8'h44);
    exp_busy = 1; exp_terr = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == rst_at_byte - 1) begin
        rx_byte = d[127-8*i -: 8]; rx_valid = 1'b1;
        do_reset();
        return;
      end
      send_byte(d[127-8*i -: 8]);
      exp_data = (old << (8*(i+1))) | (d >> (8*(15-i)));
    end
    exp_rx_ready = 0; exp_en = 1;
    cap = (k <= TO) ? k : 0;
    for (int j = 1; j <= TO; j++) begin
      core_data_out_valid = (j == 1 && stale) || (j >= k);
      core_data_out = (j == 1) ? ~res : res;
      rx_valid = 1'($urandom_range(1)); rx_byte = 8'($urandom);
      if (j == rst_at_run) begin
        do_reset();
        return;
      end
      tick();
      if (j == cap) begin
        exp_en = 0; exp_txv = 1; exp_res = res; tx_idx = 0;
        break;
      end
      if (j == TO) begin
        exp_en = 0; exp_terr = 1; exp_busy = 0; exp_rx_ready = 1;
      end
    end
    rx_valid = 1'b0;
    if (cap != 0) begin
      guard = 0;
      while (tx_idx < 16 && guard < 400) begin
        case (tx_mode)
          0: tx_ready = 1'b1;
          1: tx_ready = (guard % 4 == 0) || (guard % 4 == 3);
          default: tx_ready = 1'($urandom_range(1));
        endcase
        rx_valid = (tx_ready && tx_idx == 15) ? 1'b0 : 1'($urandom_range(1));
        rx_byte = 8'($urandom);
        core_data_out_valid = 1'($urandom_range(1));
        core_data_out = rnd128();
        tick();
        guard++;
        if (tx_ready) begin
          tx_idx++;
          if (tx_idx == 16) begin
            exp_txv = 0; exp_busy = 0; exp_rx_ready = 1;
          end
        end
      end
      tx_ready = 1'b0; rx_valid = 1'b0; core_data_out_valid = 1'b0;
      chk("tx_count", tx_log.size(), 16);
      for (int i = 0; i < 16; i++)
        if (i < tx_log.size()) chk("tx_log", tx_log[i], res[127-8*i -: 8]);
    end else begin
      chk("timeout tx_count", tx_log.size(), 0);
    end
    tick();
  endtask

  initial begin
    logic [127:0] r;
    exp_key = '0; exp_data = '0; exp_terr = 0; exp_en = 0; exp_txv = 0;
    exp_busy = 0; exp_rx_ready = 0; tx_idx = 0; exp_res = '0;
    chk_on = 1'b1;
    do_reset();

    // Reference vector with literal pins on key, data, core_en length and byte order.
    load_key(KEY_VEC);
    chk("key literal", core_key, KEY_VEC);
    run_op(DAT_VEC, RES_VEC, 20, 1'b0, 0, 0, 0);
    chk("data literal", core_data, DAT_VEC);
    chk("en cycles 20", en_cycles, 20);
    for (int i = 0; i < 16; i++)
      if (i < tx_log.size()) chk("vector byte", tx_log[i], 8'(i * 8'h11));

    // Stale valid in RUN cycle 1, real one at cycle 5, under back-pressure.
    run_op(rnd128(), rnd128(), 5, 1'b1, 1, 0, 0);
    chk("en cycles stale", en_cycles, 5);

    // Timeout, then the next 0x44 clears the flag.
    run_op(rnd128(), rnd128(), 1000, 1'b0, 0, 0, 0);
    chk("en cycles timeout", en_cycles, 64);
    chk("timeout flag", timeout_err, 1'b1);
    chk("ready after timeout", rx_ready, 1'b1);
    run_op(rnd128(), rnd128(), 2, 1'b0, 2, 0, 0);
    chk("timeout cleared", timeout_err, 1'b0);

    // Valid arriving on the last allowed cycle wins over timeout.
    run_op(rnd128(), rnd128(), TO, 1'b1, 0, 0, 0);
    chk("late valid no err", timeout_err, 1'b0);

    // Junk byte, header bytes as data, key reuse across two runs.
    send_byte(8'h55);
    run_op(128'h4b44_4b44_0102_0304_0506_0708_090a_0b0c, rnd128(), 7, 1'b0, 2, 0, 0);
    run_op(rnd128(), rnd128(), 9, 1'b1, 1, 0, 0);
    chk("key reused", core_key, KEY_VEC);

    // Reset at the 8th data byte and mid-RUN.
    run_op(rnd128(), rnd128(), 10, 1'b0, 0, 8, 0);
    load_key(rnd128());
    run_op(rnd128(), rnd128(), 30, 1'b0, 0, 0, 12);
    chk("ready after reset", rx_ready, 1'b1);

    // Randomised operations.
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(2) == 0) load_key(rnd128());
      r = rnd128();
      run_op(rnd128(), r, int'($urandom_range(2, 72)), 1'($urandom_range(1)),
             int'($urandom_range(2)), 0, 0);
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
